// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//
// Upstream configuration stage for the FIR filter. A serial stream of signed
// coefficients arrives over a valid/ready handshake and is collected in a
// shadow bank. The accepted beat that completes the bank also copies it, that
// beat included, into the parallel active bank (coeff_out). The filter sees
// one clr pulse at the start of a load and one coeff_valid strobe per commit.
//
// Handshake: a beat transfers on a rising clk edge where wr_valid and
// wr_ready are both high. wr_ready is high only in LOAD and only while abort
// is low. wr_valid in any other cycle is ignored and its data is not stored.
//
// Parameters:
//   COEFF_WIDTH  width of one signed coefficient (default 16)
//   N_TAPS       highest coefficient index; the bank holds N_TAPS+1 entries
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   load_start   single-cycle request to begin a load (honoured in IDLE only)
//   abort        cancels a load in CLEAR or LOAD; the active bank is kept
//   wr_data      coefficient beat; beat k lands in index k
//   wr_valid     wr_data is valid
//   wr_ready     beat accepted this cycle (LOAD and !abort)
//   busy         high whenever the FSM is not in IDLE
//   clr          one-cycle clear pulse to the FIR delay line
//   coeff_out    active coefficient bank, connects to FIR coeff_in
//   coeff_valid  one-cycle strobe marking a new active bank
//
// Configuration macro: FIR_COEFF_SYMMETRIC_EN
//   defined   : linear-phase mode, (N_TAPS+2)/2 beats, beat k is written to
//               both index k and index N_TAPS-k
//   undefined : N_TAPS+1 beats, no mirroring

module fir_coeff_loader #(
    parameter int COEFF_WIDTH = 16,
    parameter int N_TAPS      = 41
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load_start,
    input  logic                                abort,
    input  logic [COEFF_WIDTH-1:0]              wr_data,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    output logic                                busy,
    output logic                                clr,
    output logic [N_TAPS:0][COEFF_WIDTH-1:0]    coeff_out,
    output logic                                coeff_valid
);

`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int LOAD_COUNT = (N_TAPS + 2) / 2;
`else
    localparam int LOAD_COUNT = N_TAPS + 1;
`endif

    localparam int IDX_W = (N_TAPS > 0) ? $clog2(N_TAPS + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_COUNT - 1);
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N_TAPS);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        LOAD   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                             state;
    logic [IDX_W-1:0]                   idx;
    logic [N_TAPS:0][COEFF_WIDTH-1:0]   shadow;
    logic [N_TAPS:0][COEFF_WIDTH-1:0]   shadow_next;
    logic                               accept;

    // The only combinational output: abort must be able to refuse a beat in
    // the same cycle it is raised.
    always_comb begin
        wr_ready = (state == LOAD) && !abort;
    end

    assign accept = wr_valid && wr_ready;

    // Shadow bank as it stands after this cycle's beat. The commit edge copies
    // this rather than the registered shadow so the final beat is included.
    always_comb begin
        shadow_next = shadow;
        if (accept) begin
            shadow_next[idx] = wr_data;
`ifdef FIR_COEFF_SYMMETRIC_EN
            // When idx reaches the centre tap both writes hit the same
            // entry with the same data.
            shadow_next[TOP_IDX - idx] = wr_data;
`endif
        end
    end

    // State, index, banks and Moore outputs. clr/busy/coeff_valid are loaded
    // with the value belonging to the state being entered, so each is a clean
    // register output aligned with that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            shadow      <= '0;
            coeff_out   <= '0;
            busy        <= 1'b0;
            clr         <= 1'b0;
            coeff_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                        clr   <= 1'b1;
                    end
                end

                CLEAR: begin
                    idx <= '0;
                    clr <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        // Partial shadow contents are simply overwritten by
                        // the next load; coeff_out is left untouched.
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        shadow <= shadow_next;
                        idx    <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            coeff_out   <= shadow_next;
                            state       <= COMMIT;
                            coeff_valid <= 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    state       <= IDLE;
                    idx         <= '0;
                    busy        <= 1'b0;
                    coeff_valid <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    idx         <= '0;
                    busy        <= 1'b0;
                    clr         <= 1'b0;
                    coeff_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader.
// Reference model: the active bank is an array rebuilt from the list of beats
// of each completed load; timing expectations come from the cycle rules of
// the loader (clr one cycle after load_start, data beats from the cycle
// after that, coeff_valid the cycle after the final beat).

module tb_fir_coeff_loader;

    localparam int CW = 16;
    localparam int NT = 41;
`ifdef FIR_COEFF_SYMMETRIC_EN
    localparam int LC = (NT + 2) / 2;
`else
    localparam int LC = NT + 1;
`endif

    logic                       clk;
    logic                       rst;
    logic                       load_start;
    logic                       abort;
    logic [CW-1:0]              wr_data;
    logic                       wr_valid;
    logic                       wr_ready;
    logic                       busy;
    logic                       clr;
    logic [NT:0][CW-1:0]        coeff_out;
    logic                       coeff_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // beats of the load being driven, index k = beat k
    logic [CW-1:0] exp_q[$];
    // expected active bank
    logic [CW-1:0] model_bank [NT+1];

    typedef struct {
        logic          ls;
        logic          ab;
        logic          v;
        logic [CW-1:0] d;
        logic          e_ready;
        logic          e_busy;
        logic          e_clr;
        logic          e_cv;
    } vec_t;

    vec_t tbl [9];

    fir_coeff_loader #(
        .COEFF_WIDTH(CW),
        .N_TAPS     (NT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .abort      (abort),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .clr        (clr),
        .coeff_out  (coeff_out),
        .coeff_valid(coeff_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bank(input string name);
        int bad;
        bad = 0;
        checks++;
        for (int k = 0; k <= NT; k++) begin
            if (coeff_out[k] !== model_bank[k]) begin
                if (bad == 0)
                    $display("FAIL %s: coeff_out[%0d] got %0h expected %0h (t=%0t)",
                             name, k, coeff_out[k], model_bank[k], $time);
                bad++;
            end
        end
        if (bad != 0) errors++;
    endtask

    // bank after a completed load, straight from the load rules
    task automatic model_commit();
        for (int k = 0; k < LC; k++) begin
            model_bank[k] = exp_q[k];
`ifdef FIR_COEFF_SYMMETRIC_EN
            model_bank[NT-k] = exp_q[k];
`endif
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        load_start = 1'b0;
        abort      = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
    endtask

    task automatic fill_const(input logic [CW-1:0] val);
        exp_q.delete();
        for (int k = 0; k < LC; k++) exp_q.push_back(val);
    endtask

    task automatic fill_ramp();
        exp_q.delete();
        for (int k = 0; k < LC; k++) exp_q.push_back(CW'(k + 1));
    endtask

    task automatic fill_rand();
        exp_q.delete();
        for (int k = 0; k < LC; k++) exp_q.push_back(CW'($urandom));
    endtask

    // Drive one load of exp_q. Called and returns at posedge+1 with the DUT
    // in IDLE. mode 0: back-to-back, 1: wr_valid low every third cycle,
    // 2: random gaps. abort_at >= 0 raises abort with wr_valid on that beat.
    // poke_start pulses load_start during LOAD.
    task automatic run_load(input int mode, input int abort_at, input bit poke_start);
        int  acc;
        int  idle;
        int  t;
        int  c0;
        bit  v;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        load_start = 1'b0;
        chk("clr_after_start", clr, 1);
        chk("busy_after_start", busy, 1);
        chk("ready_in_clear", wr_ready, 0);
        chk("cv_in_clear", coeff_valid, 0);
        @(posedge clk);
        #1;
        chk("clr_one_cycle", clr, 0);
        chk("busy_in_load", busy, 1);
        acc  = 0;
        idle = 0;
        t    = 0;
        while (acc < LC && t < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (t % 3) != 2;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            wr_valid = v;
            wr_data  = v ? exp_q[acc] : CW'($urandom);
            if (poke_start && t == 3) load_start = 1'b1;
            if (acc == abort_at && v) abort = 1'b1;
            #1;
            chk("wr_ready", wr_ready, !abort);
            @(posedge clk);
            #1;
            load_start = 1'b0;
            if (abort) begin
                idle_inputs();
                chk("busy_after_abort", busy, 0);
                chk("cv_after_abort", coeff_valid, 0);
                chk("clr_after_abort", clr, 0);
                chk_bank("bank_kept_on_abort");
                return;
            end
            if (v) acc++;
            else   idle++;
            t++;
            chk("clr_in_load", clr, 0);
            if (acc < LC) begin
                chk("cv_early", coeff_valid, 0);
                chk("busy_in_load", busy, 1);
                chk_bank("bank_stable_in_load");
            end
        end
        idle_inputs();
        if (acc < LC) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: accepted %0d of %0d beats", acc, LC);
            return;
        end
        model_commit();
        chk("cv_commit", coeff_valid, 1);
        chk("busy_commit", busy, 1);
        chk("latency", cyc - c0 + 1, LC + 2 + idle);
        chk_bank("bank_after_commit");
        @(posedge clk);
        #1;
        chk("cv_one_cycle", coeff_valid, 0);
        chk("busy_after_commit", busy, 0);
        chk("ready_idle", wr_ready, 0);
        chk_bank("bank_stable_after_commit");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // ignored-command / abort-in-CLEAR sequence, starting from IDLE
        //          ls    ab    v     d        rdy   busy  clr   cv
        tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int k = 0; k <= NT; k++) model_bank[k] = '0;
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_clr", clr, 0);
        chk("rst_cv", coeff_valid, 0);
        chk("rst_ready", wr_ready, 0);
        chk_bank("rst_bank");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        // full load, 1..LC back-to-back
        fill_ramp();
        run_load(0, -1, 0);

        // bank A all 0x7FFF, then aborted 0x8000 load at beat 20
        fill_const(16'h7FFF);
        run_load(0, -1, 0);
        fill_const(16'h8000);
        run_load(0, 20, 0);

        // same ramp with wr_valid low every third cycle
        fill_ramp();
        run_load(1, -1, 0);

        // load_start pulsed mid-load must not restart or re-clear
        fill_rand();
        run_load(0, -1, 1);

        // table: IDLE writes, abort in CLEAR, load_start in LOAD, abort+valid
        for (int i = 0; i < 9; i++) begin
            load_start = tbl[i].ls;
            abort      = tbl[i].ab;
            wr_valid   = tbl[i].v;
            wr_data    = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_ready", i), wr_ready, tbl[i].e_ready);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_clr", i), clr, tbl[i].e_clr);
            chk($sformatf("tbl%0d_cv", i), coeff_valid, tbl[i].e_cv);
        end
        idle_inputs();
        chk_bank("tbl_bank_kept");

        // randomized loads with gaps, occasional abort and load_start pokes
        for (int n = 0; n < 8; n++) begin
            int ab_at;
            fill_rand();
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LC - 1)) : -1;
            run_load(2, ab_at, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        // reset in the middle of a load, at beat 10
        fill_rand();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            wr_valid = 1'b1;
            wr_data  = exp_q[k];
            @(posedge clk);
            #1;
        end
        wr_data = exp_q[10];
        #1;
        rst = 1'b1;
        for (int k = 0; k <= NT; k++) model_bank[k] = '0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_clr", clr, 0);
        chk("midrst_cv", coeff_valid, 0);
        chk("midrst_ready", wr_ready, 0);
        chk_bank("midrst_bank");
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", wr_ready, 0);
        chk_bank("post_rst_bank");

        // loader still works after reset
        fill_rand();
        run_load(0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Upstream configuration stage for the FIR filter. Accepts a serial stream of signed coefficients over a valid/ready handshake and collects them in a shadow bank. On the last beat it commits the bank to a parallel active bank. It drives the filter's `clr`, `coeff_in[N_TAPS:0]` and `coeff_valid` inputs, so a coefficient swap (LPF/HPF/BPF) takes one command and no testbench-side array writes.

## Interface
- `COEFF_WIDTH`, default 16: width of one signed coefficient.
- `N_TAPS`, default 41: highest coefficient index; the bank holds `N_TAPS+1` coefficients (42 by default).

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `load_start`  in  1: single-cycle request to begin a new load.
- `abort`  in  1: cancels a load in progress.
- `wr_data`  in  COEFF_WIDTH: signed coefficient beat.
- `wr_valid`  in  1: `wr_data` is valid.
- `wr_ready`  out  1: loader accepts a beat this cycle.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `clr`  out  1: one-cycle clear pulse to the FIR delay line.
- `coeff_out`  out  COEFF_WIDTH × [N_TAPS:0]: active coefficient bank, connects to FIR `coeff_in`.
- `coeff_valid`  out  1: one-cycle strobe marking a new active bank.

## Operation
- The FSM has four states: IDLE, CLEAR, LOAD, COMMIT. The state is registered, and `clr`, `busy` and `coeff_valid` are Moore outputs.
- `LOAD_COUNT` is `N_TAPS+1`, or see Configuration.
- **IDLE**
  - `wr_ready=0`.
  - `load_start=1` moves to CLEAR.
- **CLEAR**
  - `clr=1` and the write index resets to 0.
  - Next state is LOAD, or IDLE if `abort=1`.
- **LOAD**
  - `wr_ready = !abort`.
  - Each accepted beat (`wr_valid && wr_ready`) writes `shadow[idx]` and increments `idx`.
  - The beat with `idx==LOAD_COUNT-1` also copies the shadow bank, including that beat, into `coeff_out` on the same edge, and the FSM moves to COMMIT.
  - `abort=1` moves to IDLE. The shadow bank is discarded, `coeff_out` is unchanged and no `coeff_valid` is issued.
- **COMMIT**
  - `coeff_valid=1` and `coeff_out` already holds the new bank.
  - Next state is always IDLE; `abort` is ignored here.
- `load_start` is ignored outside IDLE.
- `wr_valid` outside LOAD is ignored, and the data is not stored.
- Gaps in `wr_valid` stall the load indefinitely, with no timeout.
- Arithmetic: coefficients are stored bit-exact with no sign extension, rounding or reordering; beat k lands in index k.
- `coeff_out` changes only on the commit edge and is stable between commits.
- Reset, at any time including mid-load:
  - state → IDLE, `idx=0`;
  - shadow bank and `coeff_out` all zero;
  - `wr_ready=0`, `busy=0`, `clr=0`, `coeff_valid=0`.

## Timing
- `load_start` sampled at edge E0:
  - cycle after E0: `clr=1`, `busy=1`, `wr_ready=0`;
  - after E1: `wr_ready=1`.
- With `wr_valid` held high, beats are accepted at edges E2 … E(LOAD_COUNT+1).
- `coeff_valid=1` in the cycle after E(LOAD_COUNT+1). This is the minimum latency: 44 cycles from `load_start` to `coeff_valid` at the defaults.
- `busy` drops in the cycle after COMMIT, and a new `load_start` is accepted in that cycle.
- `abort` and `wr_valid` in the same LOAD cycle: `abort` wins. `wr_ready` is low, so the beat is not accepted.
- Combinational paths:
  - `wr_ready` depends combinationally on `abort` only;
  - every other output is registered or decoded from state.

## Configuration
- Macro `FIR_COEFF_SYMMETRIC_EN`.
- **Defined:** the loader targets linear-phase filters.
  - `LOAD_COUNT = (N_TAPS+2)/2`, which is 21 at the defaults.
  - Beat k writes both `shadow[k]` and `shadow[N_TAPS-k]`; if the two indices coincide, the location is written once.
  - The commit and `coeff_valid` timing rules above are unchanged, with the smaller `LOAD_COUNT`.
- **Undefined:** `LOAD_COUNT = N_TAPS+1` and no mirroring; full asymmetric banks are loaded.

## Test plan
- **Reset values:** assert `rst` mid-stream at beat 10.
  - Required: all outputs 0 and `coeff_out` all zeros immediately (async).
  - After release, IDLE with `busy=0`.
- **Full load:**
  - Stimulus: `load_start`, then 42 back-to-back beats 0x0001…0x002A.
  - Required:
    - `clr` high exactly 1 cycle after `load_start`;
    - `coeff_valid` high exactly 1 cycle, 44 cycles after `load_start`;
    - `coeff_out[k]=k+1`.
- **Backpressure and gaps:** same data as the full-load test, with `wr_valid` deasserted every third cycle.
  - Required: identical `coeff_out`, and `coeff_valid` delayed by the number of idle cycles.
- **Abort keeps active bank:**
  - Stimulus: load bank A (all 0x7FFF), then start a load of 0x8000 and assert `abort` together with `wr_valid` at beat 20.
  - Required: `coeff_out` still all 0x7FFF, no `coeff_valid`, beat 20 not accepted, `busy=0` next cycle.
- **Ignored commands:** pulse `load_start` during LOAD, and drive `wr_valid` with `wr_data=0x1234` in IDLE.
  - Required: the load continues unaffected, no extra `clr`, and 0x1234 is never stored.
- **Symmetric build (`FIR_COEFF_SYMMETRIC_EN` defined):**
  - Stimulus: 21 beats 1…21.
  - Required: `coeff_out[k]=k+1` and `coeff_out[41-k]=k+1` for k=0…20, with `coeff_valid` 23 cycles after `load_start`.
